// File: rtl/versat_sched_pkg.sv
// Shared types and constants for the Versat run scheduler.
// State encoding, control-register offsets and STATUS bit positions.
package versat_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GUARD,
    S_WAIT
  } state_e;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_ITER   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TMO    = 2'd3;

  localparam int CMD_START = 0;
  localparam int CMD_ABORT = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;
  localparam int ST_TIMEOUT = 3;

endpackage

// File: rtl/versat_rr_arb2.sv
// Two-master round-robin arbiter for the accelerator memory port.
// Holds the grant until acc_ready; the pointer flips on each completion.
module versat_rr_arb2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                acc_valid,
  output logic [ADDR_W-1:0]   acc_addr,
  output logic [DATA_W/8-1:0] acc_wstrb,
  output logic [DATA_W-1:0]   acc_wdata,
  input  logic                acc_ready,
  input  logic [DATA_W-1:0]   acc_rdata
);

  logic lock_q, lock_d;
  logic own_q, own_d;
  logic rr_q, rr_d;
  logic sel, gnt;
  logic s0, s1;

  always_comb begin
    sel = own_q;
    gnt = 1'b0;
    if (lock_q) begin
      gnt = 1'b1;
    end else if (!hold && (m0_valid || m1_valid)) begin
      gnt = 1'b1;
      sel = (m0_valid && m1_valid) ? rr_q : m1_valid;
    end
  end

  assign acc_valid = gnt && (sel ? m1_valid : m0_valid);
  assign s0 = acc_valid && !sel;
  assign s1 = acc_valid && sel;

  assign acc_addr  = s1 ? m1_addr  : (s0 ? m0_addr  : '0);
  assign acc_wstrb = s1 ? m1_wstrb : (s0 ? m0_wstrb : '0);
  assign acc_wdata = s1 ? m1_wdata : (s0 ? m0_wdata : '0);

  assign m0_ready = s0 && acc_ready;
  assign m1_ready = s1 && acc_ready;
  assign m0_rdata = s0 ? acc_rdata : '0;
  assign m1_rdata = s1 ? acc_rdata : '0;

  always_comb begin
    lock_d = lock_q;
    own_d  = own_q;
    rr_d   = rr_q;
    if (acc_valid && acc_ready) begin
      lock_d = 1'b0;
      rr_d   = !sel;
    end else if (acc_valid) begin
      lock_d = 1'b1;
      own_d  = sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
      own_q  <= 1'b0;
      rr_q   <= 1'b0;
    end else begin
      lock_q <= lock_d;
      own_q  <= own_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: rtl/versat_run_sched.sv
// Versat run scheduler: run sequencing, watchdog, control registers
// and the shared accelerator memory port.
module versat_run_sched
  import versat_sched_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int CNT_W    = 16,
  parameter int TMO_W    = 20,
  parameter bit MEM_LOCK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_valid,
  input  logic [1:0]          ctrl_addr,
  input  logic [DATA_W/8-1:0] ctrl_wstrb,
  input  logic [DATA_W-1:0]   ctrl_wdata,
  output logic                ctrl_ready,
  output logic [DATA_W-1:0]   ctrl_rdata,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                acc_valid,
  output logic [ADDR_W-1:0]   acc_addr,
  output logic [DATA_W/8-1:0] acc_wstrb,
  output logic [DATA_W-1:0]   acc_wdata,
  input  logic                acc_ready,
  input  logic [DATA_W-1:0]   acc_rdata,
  output logic                acc_run,
  input  logic                acc_done,
  output logic                irq
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   iters_q, iters_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               guard_q, guard_d;
  logic               done_q, done_d;
  logic               abrt_q, abrt_d;
  logic               tout_q, tout_d;
  logic               irq_q, irq_d;
  logic               accd_q, accd_d;
  logic               rdy_q, rdy_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               acc_en, wr, busy;
  logic               start, abort;
  logic [DATA_W-1:0]  status, rd_mux;
  logic               unused_wdata;

  // A held request is acknowledged once; the write acts on its first cycle.
  assign acc_en = ctrl_valid && !rdy_q;
  assign wr     = acc_en && (|ctrl_wstrb);
  assign start  = wr && ctrl_addr == REG_CMD && ctrl_wdata[CMD_START];
  assign abort  = wr && ctrl_addr == REG_CMD && ctrl_wdata[CMD_ABORT];
  assign busy   = state_q != S_IDLE;
  assign unused_wdata = ^ctrl_wdata;

  always_comb begin
    status = '0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done_q;
    status[ST_ABORTED] = abrt_q;
    status[ST_TIMEOUT] = tout_q;
    status[DATA_W-1 -: CNT_W] = iters_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      ctrl_addr == REG_ITER:   rd_mux = DATA_W'(iter_q);
      ctrl_addr == REG_STATUS: rd_mux = status;
      ctrl_addr == REG_TMO:    rd_mux = DATA_W'(tmo_q);
      default:                 rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    rem_d   = rem_q;
    iters_d = iters_q;
    tmo_d   = tmo_q;
    wdog_d  = wdog_q;
    guard_d = guard_q;
    done_d  = done_q;
    abrt_d  = abrt_q;
    tout_d  = tout_q;
    irq_d   = 1'b0;
    accd_d  = acc_done;
    rdy_d   = acc_en;
    rdata_d = (acc_en && !wr) ? rd_mux : '0;

    if (wr && ctrl_addr == REG_ITER && !busy)
      iter_d = ctrl_wdata[CNT_W-1:0];
    if (wr && ctrl_addr == REG_TMO)
      tmo_d = ctrl_wdata[TMO_W-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          iters_d = '0;
          done_d  = 1'b0;
          abrt_d  = 1'b0;
          tout_d  = 1'b0;
          if (iter_q != '0) begin
            rem_d   = iter_q;
            state_d = S_PULSE;
          end else begin
            done_d = 1'b1;
            irq_d  = 1'b1;
          end
        end
      end
      S_PULSE: begin
        rem_d   = rem_q - CNT_W'(1);
        wdog_d  = '0;
        guard_d = 1'b0;
        state_d = S_GUARD;
      end
      // Unit done still reflects the previous run for a cycle.
      S_GUARD: begin
        guard_d = 1'b1;
        if (guard_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (accd_q) begin
          iters_d = iters_q + CNT_W'(1);
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            irq_d   = 1'b1;
          end else begin
            state_d = S_PULSE;
          end
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
          if (wdog_d == tmo_q) begin
            state_d = S_IDLE;
            tout_d  = 1'b1;
            irq_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && busy) begin
      state_d = S_IDLE;
      iters_d = iters_q;
      done_d  = done_q;
      tout_d  = tout_q;
      abrt_d  = 1'b1;
      irq_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      iter_q  <= CNT_W'(1);
      rem_q   <= '0;
      iters_q <= '0;
      tmo_q   <= '1;
      wdog_q  <= '0;
      guard_q <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      tout_q  <= 1'b0;
      irq_q   <= 1'b0;
      accd_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      rem_q   <= rem_d;
      iters_q <= iters_d;
      tmo_q   <= tmo_d;
      wdog_q  <= wdog_d;
      guard_q <= guard_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      tout_q  <= tout_d;
      irq_q   <= irq_d;
      accd_q  <= accd_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
    end
  end

  assign acc_run    = state_q == S_PULSE;
  assign irq        = irq_q;
  assign ctrl_ready = rdy_q;
  assign ctrl_rdata = rdata_q;

  versat_rr_arb2 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .hold      (MEM_LOCK && busy),
    .m0_valid  (m0_valid),
    .m0_addr   (m0_addr),
    .m0_wstrb  (m0_wstrb),
    .m0_wdata  (m0_wdata),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_addr   (m1_addr),
    .m1_wstrb  (m1_wstrb),
    .m1_wdata  (m1_wdata),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .acc_valid (acc_valid),
    .acc_addr  (acc_addr),
    .acc_wstrb (acc_wstrb),
    .acc_wdata (acc_wdata),
    .acc_ready (acc_ready),
    .acc_rdata (acc_rdata)
  );

endmodule
